// File: rtl/dot_product_4bit_pkg.sv
// Shared constants and FSM encoding for the 4-bit dot-product stage.
// Imported by the top level and the array multiplier.
package dot_product_4bit_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int OPW   = 4;
    localparam int PRODW = 8;

endpackage

// File: rtl/dot_product_4bit_arrmult.sv
// 4x4 unsigned array multiplier: partial-product rows folded in
// through ripple-carry full-adder rows, one result bit retired per row.
module ArrMult_4bit
    import dot_product_4bit_pkg::*;
(
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic [PRODW-1:0] p
);

    logic [OPW:0] part;
    logic [OPW:0] nxt;
    logic         carry;
    logic         pp_bit;

    // part holds the running sum above the bits already retired into p
    always_comb begin
        part   = {1'b0, a & {OPW{b[0]}}};
        nxt    = '0;
        carry  = 1'b0;
        pp_bit = 1'b0;
        p      = '0;
        p[0]   = part[0];
        for (int i = 1; i < OPW; i++) begin
            carry = 1'b0;
            nxt   = '0;
            for (int j = 0; j < OPW; j++) begin
                pp_bit = a[j] & b[i];
                nxt[j] = part[j+1] ^ pp_bit ^ carry;
                carry  = (part[j+1] & pp_bit)
                       | (carry & (part[j+1] ^ pp_bit));
            end
            nxt[OPW] = carry;
            part     = nxt;
            p[i]     = part[0];
        end
        p[PRODW-1:OPW] = part[OPW:1];
    end

endmodule

// File: rtl/dot_product_4bit.sv
// Multiply-accumulate stage: sums N_TERMS registered 4x4 products
// and hands the total out over a valid/ready port.
module dot_product_4bit
    import dot_product_4bit_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = PRODW + $clog2(N_TERMS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   a_in,
    input  logic [OPW-1:0]   b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result
);

    localparam int CNT_W = $clog2(N_TERMS + 1);

    state_t             state;
    state_t             state_nxt;
    logic [OPW-1:0]     op_a;
    logic [OPW-1:0]     op_b;
    logic               op_valid;
    logic [PRODW-1:0]   prod;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   count;
    logic               accept;
    logic               last;

    ArrMult_4bit u_mult (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    assign prod_ext = {{(ACC_W-PRODW){1'b0}}, prod};
    assign accept   = in_valid && in_ready;
    assign last     = (count == CNT_W'(N_TERMS - 1));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            ACCUM: begin
                in_ready = !reset && !clear;
                if (accept && last)
                    state_nxt = FLUSH;
            end
            FLUSH: state_nxt = DONE;
            DONE: begin
                if (out_valid && out_ready)
                    state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACCUM;
            op_a      <= '0;
            op_b      <= '0;
            op_valid  <= 1'b0;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (clear) begin
            state     <= ACCUM;
            op_valid  <= 1'b0;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a     <= a_in;
                op_b     <= b_in;
                op_valid <= 1'b1;
                count    <= last ? '0 : count + CNT_W'(1);
            end else begin
                op_valid <= 1'b0;
            end
            // FLUSH folds in the final product and restarts the sum
            if (state == FLUSH) begin
                result    <= acc + prod_ext;
                out_valid <= 1'b1;
                acc       <= '0;
            end else if (op_valid) begin
                acc <= acc + prod_ext;
            end
            if (state == DONE && out_valid && out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dot_product_4bit.sv
// Directed bench for dot_product_4bit with hand-computed sums.
module tb_dot_product_4bit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  a_in = '0;
    logic [3:0]  b_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [10:0] result;

    int checks = 0;
    int failures = 0;

    dot_product_4bit dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        // reset state
        step();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_result", 32'(result), 0);
        reset = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 1);

        // test 1: 15+225+0+14
        send(4'd3, 4'd5);
        send(4'd15, 4'd15);
        send(4'd0, 4'd9);
        send(4'd7, 4'd2);
        chk("t1_flush_ov", 32'(out_valid), 0);
        chk("t1_flush_rdy", 32'(in_ready), 0);
        step();
        chk("t1_ov", 32'(out_valid), 1);
        chk("t1_result", 32'(result), 254);
        chk("t1_done_rdy", 32'(in_ready), 0);
        step();
        chk("t1_ov_drop", 32'(out_valid), 0);
        chk("t1_rdy_back", 32'(in_ready), 1);

        // test 2: maximum sum
        for (int i = 0; i < 4; i++) send(4'd15, 4'd15);
        step();
        chk("t2_ov", 32'(out_valid), 1);
        chk("t2_result", 32'(result), 900);
        chk("t2_msb", 32'(result[10]), 0);
        step();

        // test 3: backpressure
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(4'(i), 4'd1);
        step();
        in_valid = 1'b1;
        a_in     = 4'd9;
        b_in     = 4'd9;
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_ov", 32'(out_valid), 1);
            chk("t3_hold_res", 32'(result), 10);
            chk("t3_hold_rdy", 32'(in_ready), 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("t3_hs_rdy", 32'(in_ready), 0);
        step();
        chk("t3_hs_ov", 32'(out_valid), 0);
        chk("t3_grp2_rdy", 32'(in_ready), 1);
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        step();
        chk("t3_grp2_ov", 32'(out_valid), 1);
        chk("t3_grp2_res", 32'(result), 324);
        step();

        // test 4: gaps in the input stream
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            a_in     = 4'd2;
            b_in     = 4'd2;
            step();
        end
        in_valid = 1'b0;
        chk("t4_ov", 32'(out_valid), 1);
        chk("t4_result", 32'(result), 16);
        step();

        // test 5: clear mid-group, offered pair is refused
        send(4'd5, 4'd5);
        send(4'd6, 4'd6);
        clear    = 1'b1;
        in_valid = 1'b1;
        a_in     = 4'd7;
        b_in     = 4'd7;
        #1;
        chk("t5_clr_rdy", 32'(in_ready), 0);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("t5_clr_ov", 32'(out_valid), 0);
        for (int i = 0; i < 4; i++) send(4'd1, 4'd1);
        chk("t5_pre_ov", 32'(out_valid), 0);
        step();
        chk("t5_ov", 32'(out_valid), 1);
        chk("t5_result", 32'(result), 4);
        step();

        // test 6: reset while in FLUSH
        for (int i = 0; i < 4; i++) send(4'd3, 4'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rst_ov", 32'(out_valid), 0);
        chk("t6_rst_res", 32'(result), 0);
        for (int i = 0; i < 4; i++) send(4'd4, 4'd4);
        step();
        chk("t6_ov", 32'(out_valid), 1);
        chk("t6_result", 32'(result), 64);
        step();
        chk("t6_ov_drop", 32'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
